// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the CPU/multi-master bus arbiter.
// Active-low signalling helpers keep the FSM compares readable.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbHold    = 2'd1,
        ArbGrant   = 2'd2,
        ArbRelease = 2'd3
    } arb_state_e;

    localparam int   ARB_MAX_MASTER = 8;
    localparam logic ENABLE_        = 1'b0;
    localparam logic DISABLE_       = 1'b1;

    // Owner index width: one bit minimum even for a single-bit index range.
    function automatic int ow_of(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and CPU hold/acknowledge bundle between the arbiter and its masters.
// slave = arbiter side, master = requesters plus CPU side.
interface bus_arbiter_if #(
    parameter int NMASTER = 2,
    parameter int OW      = bus_arbiter_pkg::ow_of(NMASTER)
);
    logic [NMASTER-1:0] breq_;
    logic [NMASTER-1:0] bgrt_;
    logic               hold_;
    logic               hlda_;
    logic [OW-1:0]      owner;
    logic               busy;
    logic               timeout_;

    modport slave (
        input  breq_, hlda_,
        output bgrt_, hold_, owner, busy, timeout_
    );

    modport master (
        output breq_, hlda_,
        input  bgrt_, hold_, owner, busy, timeout_
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin finder: first active request at or after ptr, wrapping.
// Zero latency; purely combinational, no flow control.
// Backpressure: none, the caller decides when to act on the winner.
module arb_rr_pick #(
    parameter int NMASTER = 2,
    parameter int OW      = bus_arbiter_pkg::ow_of(NMASTER)
) (
    input  logic [NMASTER-1:0] req,
    input  logic [OW-1:0]      ptr,
    output logic [OW-1:0]      winner,
    output logic               any
);
    logic [OW:0]   sum;
    logic [OW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner = '0;
        any    = |req;
        sum    = '0;
        idx    = '0;
        for (int i = NMASTER - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (OW+1)'(i);
            if (sum >= (OW+1)'(NMASTER)) begin
                sum = sum - (OW+1)'(NMASTER);
            end
            idx = sum[OW-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the shared bus between the CPU (default owner) and NMASTER round-robin masters.
// Latency: request->hold 1 edge, acknowledge->grant 1 edge, one dead cycle between tenures.
// Backpressure: a tenure lasts until the owner drops breq_ or MAX_HOLD cycles elapse.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NMASTER  = 2,
    parameter int MAX_HOLD = 16,
    parameter int OW       = ow_of(NMASTER)
) (
    input  logic        clk,
    input  logic        reset_,
    bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_HOLD);

    if (NMASTER < 2 || NMASTER > ARB_MAX_MASTER || MAX_HOLD < 2) begin : g_bad_cfg
        $error("bus_arbiter: unsupported NMASTER/MAX_HOLD");
    end

    arb_state_e         state_q,   state_d;
    logic [NMASTER-1:0] bgrt_q,    bgrt_d;
    logic               hold_q,    hold_d;
    logic [OW-1:0]      owner_q,   owner_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;
    logic [OW-1:0]      ptr_q,     ptr_d;
    logic [CW-1:0]      cnt_q,     cnt_d;

    logic [NMASTER-1:0] req;
    logic [OW-1:0]      winner;
    logic               any;
    logic               owner_req;
    logic               last_cycle;
    logic [OW-1:0]      ptr_next;

    assign req = ~bus.breq_;

    arb_rr_pick #(
        .NMASTER (NMASTER),
        .OW      (OW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign owner_req  = (bus.breq_[owner_q] == ENABLE_);
    assign last_cycle = (cnt_q == CW'(MAX_HOLD - 1));
    assign ptr_next   = (owner_q == OW'(NMASTER - 1)) ? '0 : owner_q + OW'(1);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ArbIdle;
            bgrt_q    <= '1;
            hold_q    <= DISABLE_;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= DISABLE_;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bgrt_q    <= bgrt_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bgrt_d    = bgrt_q;
        hold_d    = hold_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = DISABLE_;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        case (state_q)
            ArbIdle: begin
                // A CPU still acknowledging a previous hold must resume first.
                if (any && bus.hlda_ == DISABLE_) begin
                    hold_d  = ENABLE_;
                    state_d = ArbHold;
                end
            end
            ArbHold: begin
                if (bus.hlda_ == ENABLE_) begin
                    if (any) begin
                        bgrt_d  = ~(NMASTER'(1) << winner);
                        owner_d = winner;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ArbGrant;
                    end else begin
                        state_d = ArbRelease;
                    end
                end
            end
            ArbGrant: begin
                cnt_d = cnt_q + CW'(1);
                // A release on the final cycle counts as a normal end, not a revoke.
                if (!owner_req || last_cycle) begin
                    bgrt_d  = '1;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                    state_d = ArbRelease;
                    if (owner_req) begin
                        timeout_d = ENABLE_;
                    end
                end
            end
            ArbRelease: begin
                if (any) begin
                    state_d = ArbHold;
                end else begin
                    hold_d  = DISABLE_;
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    assign bus.bgrt_    = bgrt_q;
    assign bus.hold_    = hold_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.timeout_ = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NMASTER=2, MAX_HOLD=4): vector table plus corner-case sequences.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NMASTER(2)) bus ();

    bus_arbiter #(
        .NMASTER  (2),
        .MAX_HOLD (4)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0] breq;
        logic       hlda;
        logic [1:0] bgrt;
        logic       hold;
        logic       busy;
        logic       owner;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] breq, input logic hlda, input logic [1:0] bgrt,
                       input logic hold, input logic busy, input logic owner, input logic tmo);
        vec_t v;
        v.breq = breq; v.hlda = hlda; v.bgrt = bgrt; v.hold = hold;
        v.busy = busy; v.owner = owner; v.tmo = tmo;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner is only meaningful while busy, so it is compared only then.
    task automatic check(input string nm, input logic [1:0] eb, input logic eh,
                         input logic ebusy, input logic eo, input logic et);
        logic [5:0] act;
        logic [5:0] exp;
        act = {bus.bgrt_, bus.hold_, bus.busy, bus.timeout_, (ebusy ? bus.owner[0] : eo)};
        exp = {eb, eh, ebusy, et, eo};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {bgrt_,hold_,busy,timeout_,owner}=%b want %b", nm, act, exp);
        end
    endtask

    // Grant exclusivity and busy consistency, every cycle.
    always @(negedge clk) begin
        total++;
        if (!$onehot0(~bus.bgrt_) || (bus.busy !== (bus.bgrt_ != 2'b11))) begin
            bad++;
            $display("FAIL grant_excl: bgrt_=%b busy=%b", bus.bgrt_, bus.busy);
        end
    end

    initial begin
        reset_    = 1'b1;
        bus.breq_ = 2'b11;
        bus.hlda_ = 1'b1;
        #1 reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL reset_owner: got %b want 0", bus.owner);
        end
        reset_ = 1'b1;

        // Round-robin: both masters request, each tenure 3 cycles.
        add(2'b00, 1, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b01, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b10, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b00, 0, 2'b10, 0, 1, 0, 1);
        add(2'b01, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b11, 0, 0, 0, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b00, 0, 2'b01, 0, 1, 1, 1);
        add(2'b11, 0, 2'b11, 0, 0, 0, 1);
        add(2'b11, 0, 2'b11, 1, 0, 0, 1);
        add(2'b11, 1, 2'b11, 1, 0, 0, 1);
        // Single request from master 0, held 3 cycles.
        add(2'b10, 1, 2'b11, 0, 0, 0, 1);
        add(2'b10, 0, 2'b10, 0, 1, 0, 1);
        add(2'b10, 0, 2'b10, 0, 1, 0, 1);
        add(2'b10, 0, 2'b10, 0, 1, 0, 1);
        add(2'b11, 0, 2'b11, 0, 0, 0, 1);
        add(2'b11, 0, 2'b11, 1, 0, 0, 1);
        add(2'b11, 1, 2'b11, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.breq_ = vecs[i].breq;
            bus.hlda_ = vecs[i].hlda;
            tick();
            check($sformatf("vec%0d", i), vecs[i].bgrt, vecs[i].hold, vecs[i].busy,
                  vecs[i].owner, vecs[i].tmo);
        end

        // Timeout: master 1 (ptr=1) never releases; master 0 waits behind it.
        bus.breq_ = 2'b00; bus.hlda_ = 1'b1;
        tick(); check("to_hold", 2'b11, 0, 0, 0, 1);
        bus.hlda_ = 1'b0;
        tick(); check("to_grant", 2'b01, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); check($sformatf("to_tenure%0d", k), 2'b01, 0, 1, 1, 1);
        end
        tick(); check("to_revoke", 2'b11, 0, 0, 0, 0);
        tick(); check("to_dead", 2'b11, 0, 0, 0, 1);
        tick(); check("to_next_m0", 2'b10, 0, 1, 0, 1);
        bus.breq_ = 2'b11;
        tick(); check("to_end", 2'b11, 0, 0, 0, 1);
        tick(); check("to_idle", 2'b11, 1, 0, 0, 1);

        // Release exactly on the final allowed cycle: normal end, pointer advances.
        bus.breq_ = 2'b01; bus.hlda_ = 1'b1;
        tick(); check("sim_hold", 2'b11, 0, 0, 0, 1);
        bus.hlda_ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); check($sformatf("sim_tenure%0d", k), 2'b01, 0, 1, 1, 1);
        end
        bus.breq_ = 2'b11;
        tick(); check("sim_end_no_tmo", 2'b11, 0, 0, 0, 1);
        tick(); check("sim_idle", 2'b11, 1, 0, 0, 1);
        bus.breq_ = 2'b00; bus.hlda_ = 1'b1;
        tick(); check("sim_rehold", 2'b11, 0, 0, 0, 1);
        bus.hlda_ = 1'b0;
        tick(); check("sim_ptr_adv", 2'b10, 0, 1, 0, 1);
        bus.breq_ = 2'b11;
        tick(); tick();
        check("sim_back_idle", 2'b11, 1, 0, 0, 1);

        // Late acknowledge with the request withdrawn before it arrives.
        bus.breq_ = 2'b10; bus.hlda_ = 1'b1;
        tick(); check("late_hold", 2'b11, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) bus.breq_ = 2'b11;
            tick(); check($sformatf("late_wait%0d", k), 2'b11, 0, 0, 0, 1);
        end
        bus.hlda_ = 1'b0;
        tick(); check("late_release", 2'b11, 0, 0, 0, 1);
        tick(); check("late_idle", 2'b11, 1, 0, 0, 1);
        bus.hlda_ = 1'b1;
        tick(); check("late_stay_idle", 2'b11, 1, 0, 0, 1);

        // Reset asserted mid-tenure, then a fresh grant.
        bus.breq_ = 2'b10;
        tick(); check("rst_hold", 2'b11, 0, 0, 0, 1);
        bus.hlda_ = 1'b0;
        tick(); check("rst_grant", 2'b10, 0, 1, 0, 1);
        #3 reset_ = 1'b0;
        #1 check("rst_async", 2'b11, 1, 0, 0, 1);
        total++;
        if (bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL rst_owner: got %b want 0", bus.owner);
        end
        tick(); check("rst_held", 2'b11, 1, 0, 0, 1);
        #3 reset_ = 1'b1;
        bus.breq_ = 2'b00; bus.hlda_ = 1'b1;
        tick(); check("post_rst_hold", 2'b11, 0, 0, 0, 1);
        bus.hlda_ = 1'b0;
        tick(); check("post_rst_grant_ptr0", 2'b10, 0, 1, 0, 1);
        bus.breq_ = 2'b11;
        tick(); tick();
        check("post_rst_idle", 2'b11, 1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Bus arbiter that sits on the opposite side of the `breq_`/`bgrt_` handshake used by the DMA controller and other bus masters. The CPU owns the shared memory/I/O bus by default. When any master requests the bus, the arbiter asks the CPU to release it (`hold_`/`hlda_`), then grants it to exactly one requester in round-robin order. It revokes overlong tenures and returns the bus to the CPU once no requests remain.

## Interface
- `NMASTER`, default 2: number of requesting masters (2..8).
- `MAX_HOLD`, default 16: maximum number of Grant-state cycles per tenure (≥2).
- `OW`, default `$clog2(NMASTER)` (minimum 1): width of `owner`.

Ports:
- `clk`  in  1  sole clock; everything samples on the rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `breq_`  in  NMASTER  per-master bus request, active low.
- `bgrt_`  out  NMASTER  per-master bus grant, active low; at most one bit low at any time.
- `hold_`  out  1  request to the CPU to release the bus, active low.
- `hlda_`  in  1  CPU acknowledges it has released the bus, active low.
- `owner`  out  OW  index of the currently granted master; valid while `busy`=1.
- `busy`  out  1  high while any `bgrt_` bit is low.
- `timeout_`  out  1  one-cycle low pulse when a tenure is revoked.

## Operation
- All outputs are registered.
- Reset values: `bgrt_` all 1, `hold_`=1, `owner`=0, `busy`=0, `timeout_`=1, state=ArbIdle, rr pointer `ptr`=0, tenure counter=0.
- **Winner selection:** the first master whose `breq_` bit is low, scanning from index `ptr` upward and wrapping modulo NMASTER.
- **ArbIdle:** if any `breq_` is low and `hlda_`=1, set `hold_`<=0 and go to ArbHold. If `hlda_` is still low (the CPU has not resumed), stay in ArbIdle.
- **ArbHold:** wait for `hlda_`=0. On that edge:
  - If a request is pending: drive `bgrt_[w]`<=0, `owner`<=w, `busy`<=1, counter<=0, go to ArbGrant.
  - If all requests have been withdrawn: go to ArbRelease.
- **ArbGrant:** counter increments every cycle.
  - Normal end: `breq_[owner]`=1 → `bgrt_`<=all 1, `busy`<=0, `ptr`<=(owner+1) mod NMASTER, go to ArbRelease.
  - Revoke: counter = MAX_HOLD-1 while `breq_[owner]` is still low → same actions as normal end, plus `timeout_`<=0 for one cycle.
  - If both conditions are true on the same edge, it is a normal end; no timeout pulse.
  - Requests from other masters are ignored while in this state.
- **ArbRelease:** exactly one dead cycle with every grant high.
  - If any `breq_` is low: go back to ArbHold, keeping `hold_` low. Because `hlda_` is still low, the grant follows on the next edge.
  - Otherwise: `hold_`<=1, go to ArbIdle.
- `hlda_` rising while in ArbGrant is a CPU protocol violation. The arbiter ignores it and the tenure continues.
- Reset asserted mid-tenure immediately forces all reset values, including releasing the grant, with no dead cycle.

## Timing
- Request to hold: `breq_` sampled low at edge T0 → `hold_` low after T0.
- Acknowledge to grant: `hlda_` sampled low at edge T1 → `bgrt_` low after T1.
- Minimum latency from a request to the grant visible at the master: 2 edges.
- Release to next grant, back-to-back requests: `breq_` high sampled at edge T → grants high after T (ArbRelease) → ArbHold after T+1 → next grant after T+2.
- Longest single tenure: MAX_HOLD cycles of `bgrt_` low.
- The `timeout_` pulse coincides with the first cycle that `bgrt_` is high after a revoke.
- The arbiter must not combinationally loop `breq_` to `bgrt_`.

## Structure
- Add to `define.h`:
  - State codes `ArbIdle`, `ArbHold`, `ArbGrant`, `ArbRelease` (2-bit).
  - `ARB_MAX_MASTER` (8).
  - Reuse the existing `Enable_`/`Disable_` constants for all active-low compares.
- One sub-module, `arb_rr_pick`: combinational round-robin finder.
  - Inputs: request vector (active high), `ptr`.
  - Outputs: winner index, `any`.
- The top level holds the FSM, pointer, counter, and output registers.

## Test plan
- **Single request:** NMASTER=2, master 0 asserts `breq_`; `hlda_` follows `hold_` after 1 cycle → `bgrt_`=2'b10, `owner`=0, `busy`=1. Master 0 drops `breq_` after 5 cycles → one dead cycle, then `hold_`=1.
- **Round-robin:** both masters request continuously, each holding for 3 cycles → grant order 0,1,0,1; a dead cycle between tenures; `hold_` stays low throughout.
- **Timeout:** MAX_HOLD=4 and master 1 never releases → `bgrt_[1]` low for exactly 4 cycles, `timeout_` low for 1 cycle, then master 0 is granted if it is requesting.
- **Late acknowledge:** `hlda_` arrives 10 cycles after `hold_` and the request was withdrawn at cycle 3 → no grant ever goes low; ArbRelease then ArbIdle, `hold_` returns to 1.
- **Reset mid-tenure:** `reset_` pulsed low while master 0 is granted → `bgrt_` all 1, `hold_`=1, `busy`=0 asynchronously; after reset is released, a fresh request is granted normally.
- **Simultaneous end and timeout:** master releases on the MAX_HOLD-1 edge → no `timeout_` pulse, `ptr` advances.
